// File: rtl/fetch_address_gen_pkg.sv
// Shared types and constants for the fetch address generator and its metadata FIFO.
package fetch_address_gen_pkg;

  // Default limit on granted requests that have not yet returned data.
  localparam int FETCH_MAX_OUT = 2;

  // Per-request metadata that travels alongside a fetch and returns with its response.
  typedef struct packed {
    logic [1:0] pred;    // taken bits that steered the address after this fetch
    logic       ualign;  // first halfword of the fetched word is not part of the stream
  } fetch_meta;

  typedef enum logic [1:0] {
    FG_BOOT,
    FG_RUN,
    FG_HOLD
  } fgen_state;

  // A fetch that enters at bit1=1 never executes the lower halfword, so a
  // prediction that was taken only from that halfword must not redirect fetch.
  function automatic logic [1:0] pred_effective(input logic [1:0] pred_taken,
                                                input logic       ualign);
    return (ualign && (pred_taken == 2'b01)) ? 2'b00 : pred_taken;
  endfunction

endpackage

// File: rtl/fetch_address_gen_meta_fifo.sv
// In-order FIFO holding one metadata entry per outstanding fetch request.
module fetch_meta_fifo
  import fetch_address_gen_pkg::*;
#(
  parameter int DEPTH = FETCH_MAX_OUT
) (
  input  logic      s_clk_i,
  input  logic      s_resetn_i,
  input  logic      push,
  input  fetch_meta push_data,
  input  logic      pop,
  output fetch_meta head,
  output logic      empty,
  output logic      full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_meta     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; wrap explicitly so any DEPTH works.
  always_ff @(posedge s_clk_i) begin
    // NOTE: state uses non-blocking (<=) so every register samples pre-edge values.
    if (!s_resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only read when count says they are valid.
  always_ff @(posedge s_clk_i) begin
    // NOTE: storage array has no reset; the cleared pointers/count make stale entries unreachable.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_address_gen.sv
// Fetch-stage next-address generator: holds the fetch PC, issues word requests,
// tracks outstanding fetches and tags each response with its metadata.
module fetch_address_gen
  import fetch_address_gen_pkg::*;
#(
  parameter int MAX_OUT = FETCH_MAX_OUT
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic [31:0] s_boot_add_i,
  input  logic        s_redirect_i,
  input  logic [31:0] s_redirect_add_i,
  input  logic [1:0]  s_pred_taken_i,
  input  logic [31:0] s_pred_add_i,
  output logic [30:0] s_pred_fadd_o,
  input  logic        s_ibuf_full_i,
  output logic        s_fetch_req_o,
  output logic [31:0] s_fetch_add_o,
  input  logic        s_fetch_gnt_i,
  input  logic        s_fetch_rvalid_i,
  output logic [1:0]  s_rpred_o,
  output logic        s_rualign_o,
  output logic        s_rdiscard_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] OUT_MAX = CW'(MAX_OUT);

  fgen_state     state_q, state_d;
  logic [31:1]   fa_q, fa_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic          ualign;
  logic          fire;
  logic          rv_eff;
  logic [1:0]    pred_eff;
  fetch_meta     head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          unused_bits;

  // Halfword-aligned PC: bit1 alone tells whether the word is entered mid-way.
  assign ualign   = fa_q[1];
  assign pred_eff = pred_effective(s_pred_taken_i, ualign);

  // Request is suppressed during redirect, so a grant can only belong to a real request.
  assign fire   = s_fetch_req_o & s_fetch_gnt_i;
  // A response with nothing in flight is a leftover from before reset; ignore it.
  assign rv_eff = s_resetn_i & s_fetch_rvalid_i & (out_q != '0);

  // Bit0 of every address and the FIFO full flag carry no information here.
  assign unused_bits = ^{s_boot_add_i[0], s_redirect_add_i[0], s_pred_add_i[0], fifo_full};

  fetch_meta_fifo #(
    .DEPTH (MAX_OUT)
  ) u_meta_fifo (
    .s_clk_i    (s_clk_i),
    .s_resetn_i (s_resetn_i),
    .push       (fire),
    .push_data  ('{pred: pred_eff, ualign: ualign}),
    .pop        (rv_eff),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // Outstanding and discard counters; everything in flight at a redirect is old-stream.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    out_d = out_q;
    case ({fire, rv_eff})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
    disc_d = disc_q;
    if (s_redirect_i) begin
      disc_d = out_d;
    end else if (rv_eff && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end
  end

  // Next fetch address: redirect, then accepted prediction, then sequential word.
  always_comb begin
    fa_d = fa_q;
    if (s_redirect_i) begin
      fa_d = s_redirect_add_i[31:1];
    end else if (fire && (pred_eff != 2'b00)) begin
      fa_d = s_pred_add_i[31:1];
    end else if (fire) begin
      fa_d = {fa_q[31:2] + 30'd1, 1'b0};
    end
  end

  // Next state: stall when the in-flight window fills or the buffer is full.
  always_comb begin
    state_d = state_q;
    if (s_redirect_i) begin
      state_d = FG_RUN;
    end else begin
      case (state_q)
        FG_BOOT:        state_d = FG_RUN;
        FG_RUN, FG_HOLD: state_d = ((out_d == OUT_MAX) || s_ibuf_full_i) ? FG_HOLD : FG_RUN;
        default:        state_d = FG_BOOT;
      endcase
    end
  end

  // Outputs: request qualification, word address and response metadata.
  always_comb begin
    s_fetch_req_o = s_resetn_i & (state_q == FG_RUN) & ~s_redirect_i &
                    (out_q < OUT_MAX) & ~s_ibuf_full_i;
    s_fetch_add_o = {fa_q[31:2], 2'b00};
    s_pred_fadd_o = fa_q;
    s_rpred_o     = rv_eff ? head.pred : 2'b00;
    s_rualign_o   = rv_eff & head.ualign;
    s_rdiscard_o  = rv_eff & (disc_q != '0);
  end

  // State register.
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) state_q <= FG_BOOT;
    else             state_q <= state_d;
  end

  // Fetch address and counter registers; reset drops all in-flight tracking.
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      fa_q   <= s_boot_add_i[31:1];
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      fa_q   <= fa_d;
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  // Counters can never leave their legal range; FIFO occupancy tracks out_q.
  always_ff @(posedge s_clk_i) begin
    if (s_resetn_i) begin
      assert (out_q <= OUT_MAX);
      assert (disc_q <= out_q);
      assert (fifo_empty == (out_q == '0));
    end
  end

endmodule

// File: tb/tb_fetch_address_gen.sv
// Directed bench for fetch_address_gen with hand-computed expectations.
module tb_fetch_address_gen;

  logic        s_clk_i;
  logic        s_resetn_i;
  logic [31:0] s_boot_add_i;
  logic        s_redirect_i;
  logic [31:0] s_redirect_add_i;
  logic [1:0]  s_pred_taken_i;
  logic [31:0] s_pred_add_i;
  logic [30:0] s_pred_fadd_o;
  logic        s_ibuf_full_i;
  logic        s_fetch_req_o;
  logic [31:0] s_fetch_add_o;
  logic        s_fetch_gnt_i;
  logic        s_fetch_rvalid_i;
  logic [1:0]  s_rpred_o;
  logic        s_rualign_o;
  logic        s_rdiscard_o;

  int n_cmp = 0;
  int n_mis = 0;

  fetch_address_gen #(.MAX_OUT(2)) dut (
    .s_clk_i          (s_clk_i),
    .s_resetn_i       (s_resetn_i),
    .s_boot_add_i     (s_boot_add_i),
    .s_redirect_i     (s_redirect_i),
    .s_redirect_add_i (s_redirect_add_i),
    .s_pred_taken_i   (s_pred_taken_i),
    .s_pred_add_i     (s_pred_add_i),
    .s_pred_fadd_o    (s_pred_fadd_o),
    .s_ibuf_full_i    (s_ibuf_full_i),
    .s_fetch_req_o    (s_fetch_req_o),
    .s_fetch_add_o    (s_fetch_add_o),
    .s_fetch_gnt_i    (s_fetch_gnt_i),
    .s_fetch_rvalid_i (s_fetch_rvalid_i),
    .s_rpred_o        (s_rpred_o),
    .s_rualign_o      (s_rualign_o),
    .s_rdiscard_o     (s_rdiscard_o)
  );

  initial s_clk_i = 1'b0;
  always #5 s_clk_i = ~s_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge, then let new inputs settle.
  task automatic tick();
    @(posedge s_clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] pred, input logic ualign,
                            input logic discard);
    check({tag, "_rpred"},    {30'd0, s_rpred_o},    {30'd0, pred});
    check({tag, "_rualign"},  {31'd0, s_rualign_o},  {31'd0, ualign});
    check({tag, "_rdiscard"}, {31'd0, s_rdiscard_o}, {31'd0, discard});
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] add);
    check({tag, "_req"}, {31'd0, s_fetch_req_o}, {31'd0, req});
    if (req) check({tag, "_add"}, s_fetch_add_o, add);
  endtask

  initial begin
    s_resetn_i       = 1'b0;
    s_boot_add_i     = 32'h0000_1002;
    s_redirect_i     = 1'b0;
    s_redirect_add_i = 32'h0;
    s_pred_taken_i   = 2'b00;
    s_pred_add_i     = 32'h0;
    s_ibuf_full_i    = 1'b0;
    s_fetch_gnt_i    = 1'b0;
    s_fetch_rvalid_i = 1'b0;

    // Reset state.
    tick(); tick();
    settle();
    check("rst_req",   {31'd0, s_fetch_req_o}, 32'd0);
    check("rst_fadd",  {1'b0, s_pred_fadd_o},  32'h0000_0801);
    check("rst_add",   s_fetch_add_o,          32'h0000_1000);
    check_resp("rst", 2'b00, 1'b0, 1'b0);

    // BOOT cycle: no request yet.
    s_resetn_i = 1'b1;
    settle();
    check_req("boot", 1'b0, 32'h0);

    // First request at 0x1000 (entered at halfword 0x1002).
    tick();
    s_fetch_gnt_i = 1'b1;
    settle();
    check_req("seq0", 1'b1, 32'h0000_1000);

    // 0x1004 issued while 0x1000 returns with rualign=1.
    tick();
    s_fetch_rvalid_i = 1'b1;
    settle();
    check_req("seq1", 1'b1, 32'h0000_1004);
    check("seq1_fadd", {1'b0, s_pred_fadd_o}, 32'h0000_0802);
    check_resp("r1000", 2'b00, 1'b1, 1'b0);

    // 0x1008 predicted taken (2'b10) to 0x2006; 0x1004 returns.
    tick();
    s_pred_taken_i = 2'b10;
    s_pred_add_i   = 32'h0000_2006;
    settle();
    check_req("seq2", 1'b1, 32'h0000_1008);
    check_resp("r1004", 2'b00, 1'b0, 1'b0);

    // Word 0x2004 entered unaligned; lower-halfword prediction must be ignored.
    tick();
    s_pred_taken_i = 2'b01;
    s_pred_add_i   = 32'h0000_5000;
    settle();
    check_req("pred_tgt", 1'b1, 32'h0000_2004);
    check("pred_fadd", {1'b0, s_pred_fadd_o}, 32'h0000_1003);
    check_resp("r1008", 2'b10, 1'b0, 1'b0);

    // Sequential after ignored prediction; 0x2004 returns unaligned, pred masked.
    tick();
    s_pred_taken_i = 2'b00;
    settle();
    check_req("mask", 1'b1, 32'h0000_2008);
    check_resp("r2004", 2'b00, 1'b1, 1'b0);

    // Issue 0x200C with no response: two outstanding afterwards.
    tick();
    s_fetch_rvalid_i = 1'b0;
    settle();
    check_req("fill", 1'b1, 32'h0000_200C);

    // Window full: request drops, predictor address still presented.
    tick();
    s_fetch_gnt_i = 1'b0;
    settle();
    check_req("full", 1'b0, 32'h0);
    check("full_fadd", {1'b0, s_pred_fadd_o}, 32'h0000_1008);

    // One response frees a slot.
    tick();
    s_fetch_rvalid_i = 1'b1;
    settle();
    check_req("full_rv", 1'b0, 32'h0);
    check_resp("r2008", 2'b00, 1'b0, 1'b0);

    // Request reasserts the next cycle.
    tick();
    s_fetch_rvalid_i = 1'b0;
    s_fetch_gnt_i    = 1'b1;
    settle();
    check_req("reopen", 1'b1, 32'h0000_2010);

    // Redirect to 0x3000 with two outstanding.
    tick();
    s_fetch_gnt_i    = 1'b0;
    s_redirect_i     = 1'b1;
    s_redirect_add_i = 32'h0000_3000;
    settle();
    check_req("redir", 1'b0, 32'h0);

    // First old-stream response discarded; window still full.
    tick();
    s_redirect_i     = 1'b0;
    s_fetch_rvalid_i = 1'b1;
    settle();
    check_req("disc0", 1'b0, 32'h0);
    check("disc0_add", s_fetch_add_o, 32'h0000_3000);
    check_resp("disc0", 2'b00, 1'b0, 1'b1);

    // 0x3000 issued while the second old response is discarded.
    tick();
    s_fetch_gnt_i = 1'b1;
    settle();
    check_req("disc1", 1'b1, 32'h0000_3000);
    check_resp("disc1", 2'b00, 1'b0, 1'b1);

    // Response of 0x3000 is kept.
    tick();
    s_fetch_gnt_i = 1'b0;
    settle();
    check("keep_add", s_fetch_add_o, 32'h0000_3004);
    check_resp("keep", 2'b00, 1'b0, 1'b0);

    // Redirect to the last word of the address space.
    tick();
    s_fetch_rvalid_i = 1'b0;
    s_redirect_i     = 1'b1;
    s_redirect_add_i = 32'hFFFF_FFFC;
    settle();
    check_req("redir2", 1'b0, 32'h0);

    tick();
    s_redirect_i  = 1'b0;
    s_fetch_gnt_i = 1'b1;
    settle();
    check_req("top", 1'b1, 32'hFFFF_FFFC);

    // Sequential increment wraps to 0.
    tick();
    settle();
    check_req("wrap", 1'b1, 32'h0000_0000);

    // Reset with two outstanding: outputs cleared immediately.
    tick();
    s_fetch_gnt_i = 1'b0;
    s_resetn_i    = 1'b0;
    s_boot_add_i  = 32'h0000_4000;
    settle();
    check_req("rst2", 1'b0, 32'h0);

    // Stray response after reset: ignored, no discard flag.
    tick();
    s_resetn_i       = 1'b1;
    s_fetch_rvalid_i = 1'b1;
    settle();
    check_req("stray", 1'b0, 32'h0);
    check("stray_fadd", {1'b0, s_pred_fadd_o}, 32'h0000_2000);
    check_resp("stray", 2'b00, 1'b0, 1'b0);

    // No underflow: request is free to issue from the boot address.
    tick();
    s_fetch_rvalid_i = 1'b0;
    settle();
    check_req("post_rst", 1'b1, 32'h0000_4000);
    s_ibuf_full_i = 1'b1;
    settle();
    check_req("ibuf_full", 1'b0, 32'h0);

    // Buffer frees up: one HOLD cycle, then request resumes.
    tick();
    s_ibuf_full_i = 1'b0;
    settle();
    check_req("hold_ib", 1'b0, 32'h0);

    tick();
    settle();
    check_req("resume", 1'b1, 32'h0000_4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
